i2s_tx: RTL

//  I2S (Philips) master transmitter: final stage of the audio path, downstream of
//  the effects pipeline and the mirror of i2s_rx. Accepts stereo sample pairs via

---
 rtl/i2s_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// I2S (Philips) master transmitter.
// Stereo sample pairs are accepted via valid/ready into a one-entry holding
// buffer. At every frame start the buffer is copied into the per-channel shift
// registers, and the words are sent MSB first. Each word starts one sclk after
// the ws transition. If the buffer is empty at frame start, the frame is sent
// as silence and the underrun output pulses for one cycle.
module i2s_tx #(
  parameter int AUDIO_DW = 16,
  parameter int SLOT_W   = 32
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic [AUDIO_DW-1:0] left_in,
  input  logic [AUDIO_DW-1:0] right_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                ws,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);

  // The slot must hold the one-bit I2S delay plus the whole word.
  if (SLOT_W < AUDIO_DW + 1) begin : g_slot_too_short
    $error("i2s_tx: SLOT_W must be at least AUDIO_DW+1");
  end

  localparam int KW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // Slot position and channel
  logic [KW-1:0]       k_q, k_d;
  chan_e               chan_q, chan_d;

  // Holding buffer (one stereo pair)
  logic                full_q, full_d;
  logic [AUDIO_DW-1:0] buf_l_q, buf_l_d;
  logic [AUDIO_DW-1:0] buf_r_q, buf_r_d;

  // Per-channel shift registers for the frame currently on the wire
  logic [AUDIO_DW-1:0] sh_l_q, sh_l_d;
  logic [AUDIO_DW-1:0] sh_r_q, sh_r_d;

  // Registered outputs
  logic                ws_q, ws_d;
  logic                sdata_q, sdata_d;
  logic                ready_q, ready_d;
  logic                fs_q, fs_d;
  logic                ur_q, ur_d;

  // Decode helpers
  logic                slot_end;
  logic                frame_load;
  logic                xfer;
  logic                bit_slot;

  // Next-state logic: slot counter, frame-start load, input transfer and serialiser
  always_comb begin
    k_d        = k_q;
    chan_d     = chan_q;
    full_d     = full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;
    ws_d       = ws_q;
    sdata_d    = 1'b0;
    ready_d    = ready_q;
    fs_d       = 1'b0;
    ur_d       = 1'b0;

    slot_end   = (k_q == KW'(SLOT_W - 1));
    frame_load = slot_end && (chan_q == CH_RIGHT);
    xfer       = in_valid && ready_q;

    // Advance the bit position. When the counter wraps, switch to the other channel.
    if (slot_end) begin
      k_d    = '0;
      chan_d = (chan_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
    end else begin
      k_d    = k_q + KW'(1);
    end

    // Frame start loads the shift registers from the buffer.
    // The load samples the buffer state from before this edge. A pair that
    // arrives in the same cycle does not take part and waits for the next frame.
    if (frame_load) begin
      fs_d = 1'b1;
      if (full_q) begin
        sh_l_d = buf_l_q;
        sh_r_d = buf_r_q;
        full_d = 1'b0;
      end else begin
        sh_l_d = '0;
        sh_r_d = '0;
        ur_d   = 1'b1;
      end
    end

    // Input transfer can happen only while the buffer is empty, so it never
    // overwrites a pending pair.
    if (xfer) begin
      buf_l_d = left_in;
      buf_r_d = right_in;
      full_d  = 1'b1;
    end

    // Bit positions 1..AUDIO_DW of a slot carry the word, MSB first.
    // Position 0 and the positions after the LSB are sent as 0.
    bit_slot = (k_d != '0) && (k_d <= KW'(AUDIO_DW));
    if (bit_slot) begin
      if (chan_d == CH_LEFT) begin
        sdata_d = sh_l_q[AUDIO_DW-1];
        sh_l_d  = sh_l_q << 1;
      end else begin
        sdata_d = sh_r_q[AUDIO_DW-1];
        sh_r_d  = sh_r_q << 1;
      end
    end

    ws_d    = chan_d;
    ready_d = ~full_d;
  end

  // State register with synchronous active-low reset. Reset aborts a frame in progress.
  always_ff @(posedge sclk) begin
    if (!rst) begin
      k_q     <= KW'(SLOT_W - 1);
      chan_q  <= CH_RIGHT;
      full_q  <= 1'b0;
      buf_l_q <= '0;
      buf_r_q <= '0;
      sh_l_q  <= '0;
      sh_r_q  <= '0;
      ws_q    <= 1'b1;
      sdata_q <= 1'b0;
      ready_q <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      k_q     <= k_d;
      chan_q  <= chan_d;
      full_q  <= full_d;
      buf_l_q <= buf_l_d;
      buf_r_q <= buf_r_d;
      sh_l_q  <= sh_l_d;
      sh_r_q  <= sh_r_d;
      ws_q    <= ws_d;
      sdata_q <= sdata_d;
      ready_q <= ready_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
    end
  end

  assign in_ready    = ready_q;
  assign ws          = ws_q;
  assign sdata       = sdata_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule
